// File: rtl/modexp_pkg.sv
// modexp_pkg: shared types for the modular exponentiation controller.
//   state_t : controller FSM states
//   op_t    : tags which operation is in flight in the modulo unit, so that
//             the remainder returned in WAIT is written to the correct register
package modexp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        SQR,
        MUL,
        WAIT,
        FINISH
    } state_t;

    typedef enum logic [1:0] {
        OP_RED,
        OP_SQR,
        OP_MUL
    } op_t;

endpackage

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: computes result = base^exponent mod modulus by left-to-right
// square-and-multiply. It owns the DATA_WIDTH x DATA_WIDTH multiplier and
// drives one external modulo unit, which sits beside this block in the parent.
// The modulo unit is bypassed whenever an operand is already below the modulus.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req                 start pulse, only sampled in IDLE
//   base/exponent/modulus operands, latched when req is accepted
//   busy                high from the cycle after acceptance until valid
//   valid               one-cycle completion pulse
//   error               qualified by valid: modulus==0 (or modulo timeout)
//   result              held from valid until the next completion
//   mod_a/mod_m         dividend / modulant driven to the modulo unit
//   mod_start           one-cycle launch pulse to the modulo unit
//   mod_out/mod_done    remainder and done level from the modulo unit
//
// Optional feature macro: MODEXP_TIMEOUT_EN
//   Defined   : each modulo operation may spend at most MOD_TIMEOUT cycles in
//               WAIT; on expiry the operation finishes with error=1, result=0.
//   Undefined : WAIT only exits on mod_done or reset; MOD_TIMEOUT is unused.
module modexp_ctrl
    import modexp_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int EXP_WIDTH   = 8,
    parameter int MOD_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic [DATA_WIDTH-1:0]   base,
    input  logic [EXP_WIDTH-1:0]    exponent,
    input  logic [DATA_WIDTH-1:0]   modulus,
    output logic                    busy,
    output logic                    valid,
    output logic                    error,
    output logic [DATA_WIDTH-1:0]   result,
    output logic [2*DATA_WIDTH:0]   mod_a,
    output logic [DATA_WIDTH-1:0]   mod_m,
    output logic                    mod_start,
    input  logic [DATA_WIDTH-1:0]   mod_out,
    input  logic                    mod_done
);

    localparam int PW = 2*DATA_WIDTH + 1;
    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [IW-1:0]         I_TOP = IW'(EXP_WIDTH - 1);
    localparam logic [IW-1:0]         I_ONE = IW'(1);
    localparam logic [DATA_WIDTH-1:0] D_ONE = DATA_WIDTH'(1);

    state_t                  state_r, state_n;
    op_t                     op_r, op_n;
    logic [EXP_WIDTH-1:0]    e_r, e_n;
    logic [DATA_WIDTH-1:0]   acc_r, acc_n;
    logic [DATA_WIDTH-1:0]   b_r, b_n;
    logic [IW-1:0]           i_r, i_n;
    logic                    err_r, err_n;

    logic                    busy_n, valid_n, error_n, mod_start_n;
    logic [DATA_WIDTH-1:0]   result_n, mod_m_n;
    logic [PW-1:0]           mod_a_n;

    logic [2*DATA_WIDTH-1:0] acc_w, b_w;
    logic [PW-1:0]           p, m_w;
    logic                    p_small, e_bit, last_bit;
    state_t                  bit_state;
    logic [IW-1:0]           bit_i;

`ifdef MODEXP_TIMEOUT_EN
    localparam int CW = $clog2(MOD_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(MOD_TIMEOUT - 1);
    localparam logic [CW-1:0] TMO_ONE  = CW'(1);
    logic [CW-1:0] tmo_r, tmo_n;
`else
    logic unused_timeout;
    assign unused_timeout = (MOD_TIMEOUT != 0);
`endif

    assign acc_w = {{DATA_WIDTH{1'b0}}, acc_r};
    assign b_w   = {{DATA_WIDTH{1'b0}}, b_r};
    assign m_w   = {{(PW-DATA_WIDTH){1'b0}}, mod_m};

    // Candidate product of the current op step; the destination can take it
    // directly when it is already reduced, otherwise it goes to the modulo unit.
    always_comb begin
        p = '0;
        case (state_r)
            REDUCE:  p = {{(PW-DATA_WIDTH){1'b0}}, b_r};
            SQR:     p = {1'b0, acc_w * acc_w};
            MUL:     p = {1'b0, acc_w * b_w};
            default: p = '0;
        endcase
    end

    assign p_small  = (p < m_w);
    assign e_bit    = e_r[i_r];
    assign last_bit = (i_r == '0);

    // Where the sequencer goes once the current exponent bit is fully handled.
    assign bit_state = last_bit ? FINISH : SQR;
    assign bit_i     = last_bit ? i_r : (i_r - I_ONE);

    // Next-state and datapath update. mod_done is ignored while mod_start is
    // still high: the launch edge has not reached the modulo unit yet, so its
    // done level may still belong to the previous operation.
    always_comb begin
        state_n     = state_r;
        op_n        = op_r;
        e_n         = e_r;
        acc_n       = acc_r;
        b_n         = b_r;
        i_n         = i_r;
        err_n       = err_r;
        busy_n      = busy;
        valid_n     = 1'b0;
        error_n     = error;
        result_n    = result;
        mod_a_n     = mod_a;
        mod_m_n     = mod_m;
        mod_start_n = 1'b0;
`ifdef MODEXP_TIMEOUT_EN
        tmo_n       = tmo_r;
`endif
        case (state_r)
            IDLE: begin
                if (req) begin
                    e_n     = exponent;
                    b_n     = base;
                    mod_m_n = modulus;
                    busy_n  = 1'b1;
                    if (modulus == '0) begin
                        err_n   = 1'b1;
                        state_n = FINISH;
                    end else begin
                        err_n   = 1'b0;
                        acc_n   = (modulus == D_ONE) ? '0 : D_ONE;
                        i_n     = I_TOP;
                        state_n = REDUCE;
                    end
                end
            end
            REDUCE, SQR, MUL: begin
                if (p_small) begin
                    case (state_r)
                        REDUCE: begin
                            b_n     = p[DATA_WIDTH-1:0];
                            state_n = SQR;
                        end
                        SQR: begin
                            acc_n = p[DATA_WIDTH-1:0];
                            if (e_bit) begin
                                state_n = MUL;
                            end else begin
                                state_n = bit_state;
                                i_n     = bit_i;
                            end
                        end
                        default: begin
                            acc_n   = p[DATA_WIDTH-1:0];
                            state_n = bit_state;
                            i_n     = bit_i;
                        end
                    endcase
                end else begin
                    mod_a_n     = p;
                    mod_start_n = 1'b1;
                    op_n        = (state_r == REDUCE) ? OP_RED :
                                  (state_r == SQR)    ? OP_SQR : OP_MUL;
                    state_n     = WAIT;
`ifdef MODEXP_TIMEOUT_EN
                    tmo_n       = '0;
`endif
                end
            end
            WAIT: begin
                if (mod_done && !mod_start) begin
                    case (op_r)
                        OP_RED: begin
                            b_n     = mod_out;
                            state_n = SQR;
                        end
                        OP_SQR: begin
                            acc_n = mod_out;
                            if (e_bit) begin
                                state_n = MUL;
                            end else begin
                                state_n = bit_state;
                                i_n     = bit_i;
                            end
                        end
                        default: begin
                            acc_n   = mod_out;
                            state_n = bit_state;
                            i_n     = bit_i;
                        end
                    endcase
                end
`ifdef MODEXP_TIMEOUT_EN
                else if (tmo_r == TMO_LAST) begin
                    err_n   = 1'b1;
                    state_n = FINISH;
                end else begin
                    tmo_n = tmo_r + TMO_ONE;
                end
`endif
            end
            FINISH: begin
                valid_n  = 1'b1;
                busy_n   = 1'b0;
                error_n  = err_r;
                result_n = err_r ? '0 : acc_r;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, datapath and registered outputs; reset aborts any operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            op_r      <= OP_RED;
            e_r       <= '0;
            acc_r     <= '0;
            b_r       <= '0;
            i_r       <= '0;
            err_r     <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            error     <= 1'b0;
            result    <= '0;
            mod_a     <= '0;
            mod_m     <= '0;
            mod_start <= 1'b0;
`ifdef MODEXP_TIMEOUT_EN
            tmo_r     <= '0;
`endif
        end else begin
            state_r   <= state_n;
            op_r      <= op_n;
            e_r       <= e_n;
            acc_r     <= acc_n;
            b_r       <= b_n;
            i_r       <= i_n;
            err_r     <= err_n;
            busy      <= busy_n;
            valid     <= valid_n;
            error     <= error_n;
            result    <= result_n;
            mod_a     <= mod_a_n;
            mod_m     <= mod_m_n;
            mod_start <= mod_start_n;
`ifdef MODEXP_TIMEOUT_EN
            tmo_r     <= tmo_n;
`endif
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb_modexp_ctrl: self-checking bench for modexp_ctrl. A behavioural modulo
// unit with adjustable latency answers mod_start; results are compared with a
// plain repeated-multiplication reference model.
module tb_modexp_ctrl;

    localparam int TB_TIMEOUT = 64;
    localparam int BUDGET     = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [7:0]  base, exponent, modulus;
    logic        busy, valid, error;
    logic [7:0]  result;
    logic [16:0] mod_a;
    logic [7:0]  mod_m;
    logic        mod_start;
    logic [7:0]  mod_out  = 8'd0;
    logic        mod_done = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    modexp_ctrl #(
        .DATA_WIDTH (8),
        .EXP_WIDTH  (8),
        .MOD_TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .base     (base),
        .exponent (exponent),
        .modulus  (modulus),
        .busy     (busy),
        .valid    (valid),
        .error    (error),
        .result   (result),
        .mod_a    (mod_a),
        .mod_m    (mod_m),
        .mod_start(mod_start),
        .mod_out  (mod_out),
        .mod_done (mod_done)
    );

    always #5 clk = ~clk;

    // Behavioural modulo unit: start clears done, the remainder appears after
    // mdl_lat cycles and done then stays high until the next start.
    int          mdl_lat   = 2;
    int          mdl_cnt   = 0;
    logic [16:0] mdl_val   = 17'd0;
    logic        force_low = 1'b0;

    always @(posedge clk) begin
        if (mod_start) begin
            mod_done <= 1'b0;
            mdl_cnt  <= mdl_lat;
            mdl_val  <= mod_a % {9'd0, mod_m};
        end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1 && !force_low) begin
                mod_done <= 1'b1;
                mod_out  <= mdl_val[7:0];
            end
        end
    end

    // Interface monitor: launch pulse count and width, modulant stability.
    int         start_pulses = 0;
    int         start_wide   = 0;
    int         mod_m_bad    = 0;
    logic       prev_start   = 1'b0;
    logic [7:0] exp_m        = 8'd0;

    always @(negedge clk) begin
        if (!reset) begin
            if (mod_start && !prev_start) start_pulses++;
            if (mod_start && prev_start)  start_wide++;
            if (busy && mod_m !== exp_m)  mod_m_bad++;
            prev_start = mod_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    function automatic logic [7:0] ref_modexp(int b, int e, int m);
        longint r;
        if (m == 0) return 8'd0;
        r = 1 % m;
        for (int k = 0; k < e; k++) r = (r * b) % m;
        return 8'(r);
    endfunction

    // Issues one request at a negedge and waits (bounded) for valid.
    task automatic run_op(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                          output logic got_valid, output logic [7:0] res, output logic err,
                          output int cyc, output logic busy1, output logic valid_after);
        exp_m    = m;
        base     = b;
        exponent = e;
        modulus  = m;
        req      = 1'b1;
        @(negedge clk);
        req   = 1'b0;
        busy1 = busy;
        cyc   = 1;
        while (!valid && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        got_valid = valid;
        res       = result;
        err       = error;
        @(negedge clk);
        valid_after = valid;
    endtask

    task automatic test_reset;
        @(negedge clk);
        vectors++;
        if ({busy, valid, error, result, mod_start, mod_a, mod_m} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {busy, valid, error, result, mod_start, mod_a, mod_m});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, valid} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: got busy/valid %b expected 00", {busy, valid});
        end
    endtask

    task automatic test_known;
        logic [7:0] tb_b[5] = '{8'd4, 8'd5, 8'd200, 8'd77, 8'd255};
        logic [7:0] tb_e[5] = '{8'd13, 8'd0, 8'd9, 8'd200, 8'd255};
        logic [7:0] tb_m[5] = '{8'd7, 8'd13, 8'd1, 8'd0, 8'd251};
        logic [7:0] tb_r[5] = '{8'd4, 8'd1, 8'd0, 8'd0, 8'd20};
        logic       tb_x[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic gv, err, b1, va;
        logic [7:0] res;
        int cyc;
        for (int k = 0; k < 5; k++) begin
            mdl_lat      = k + 1;
            start_pulses = 0;
            run_op(tb_b[k], tb_e[k], tb_m[k], gv, res, err, cyc, b1, va);
            vectors++;
            if (gv !== 1'b1 || res !== tb_r[k] || err !== tb_x[k]) begin
                miscompares++;
                $display("[TB] FAIL known_%0d: got valid=%b result=%0d error=%b expected valid=1 result=%0d error=%b",
                         k, gv, res, err, tb_r[k], tb_x[k]);
            end
            vectors++;
            if (va !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL valid_width_%0d: got valid=%b a cycle later expected 0", k, va);
            end
            if (k == 1) begin
                vectors++;
                if (start_pulses !== 0 || cyc !== 11) begin
                    miscompares++;
                    $display("[TB] FAIL exp_zero_bypass: got starts=%0d latency=%0d expected 0 and 11",
                             start_pulses, cyc);
                end
            end
            if (k == 2) begin
                vectors++;
                if (start_pulses < 1) begin
                    miscompares++;
                    $display("[TB] FAIL reduce_uses_modulo: got starts=%0d expected >=1", start_pulses);
                end
            end
            if (k == 3) begin
                vectors++;
                if (cyc !== 2 || start_pulses !== 0 || b1 !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL mod_zero: got latency=%0d starts=%0d busy=%b expected 2, 0, 1",
                             cyc, start_pulses, b1);
                end
            end
            if (k == 4) begin
                vectors++;
                if (start_wide !== 0 || mod_m_bad !== 0 || start_pulses < 1) begin
                    miscompares++;
                    $display("[TB] FAIL start_and_modulant: got wide=%0d mbad=%0d starts=%0d expected 0, 0, >=1",
                             start_wide, mod_m_bad, start_pulses);
                end
            end
        end
    endtask

    task automatic test_random;
        logic gv, err, b1, va;
        logic [7:0] res, b, e, m, exp_r;
        int cyc;
        for (int n = 0; n < 24; n++) begin
            b       = 8'($urandom_range(0, 255));
            e       = 8'($urandom_range(0, 255));
            m       = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            mdl_lat = $urandom_range(1, 5);
            exp_r   = ref_modexp(int'(b), int'(e), int'(m));
            run_op(b, e, m, gv, res, err, cyc, b1, va);
            vectors++;
            if (gv !== 1'b1 || res !== exp_r || err !== (m == 8'd0)) begin
                miscompares++;
                $display("[TB] FAIL random %0d^%0d mod %0d: got valid=%b result=%0d error=%b expected 1, %0d, %b",
                         b, e, m, gv, res, err, exp_r, (m == 8'd0));
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int extra;
        mdl_lat  = 3;
        exp_m    = 8'd7;
        base     = 8'd4;
        exponent = 8'd13;
        modulus  = 8'd7;
        req      = 1'b1;
        @(negedge clk);
        base     = 8'd7;
        exponent = 8'd3;
        modulus  = 8'd11;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_busy: got %b expected 1", busy);
        end
        repeat (3) @(negedge clk);
        req = 1'b0;
        cyc = 4;
        while (!valid && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (valid !== 1'b1 || result !== 8'd4) begin
            miscompares++;
            $display("[TB] FAIL b2b_result: got valid=%b result=%0d expected 1, 4", valid, result);
        end
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (valid) extra++;
        end
        vectors++;
        if (extra !== 0 || result !== 8'd4 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_ignored: got extra=%0d result=%0d busy=%b expected 0, 4, 0",
                     extra, result, busy);
        end
    endtask

    task automatic test_reset_in_wait;
        logic gv, err, b1, va;
        logic [7:0] res;
        int cyc;
        mdl_lat  = 40;
        exp_m    = 8'd251;
        base     = 8'd255;
        exponent = 8'd255;
        modulus  = 8'd251;
        req      = 1'b1;
        @(negedge clk);
        req = 1'b0;
        cyc = 1;
        while (!mod_start && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (mod_start !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reach_wait: got mod_start=%b expected 1", mod_start);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if ({busy, valid, error, result, mod_start, mod_a, mod_m} !== '0) begin
            miscompares++;
            $display("[TB] FAIL abort_outputs: got %h expected 0",
                     {busy, valid, error, result, mod_start, mod_a, mod_m});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mdl_lat = 2;
        run_op(8'd3, 8'd5, 8'd11, gv, res, err, cyc, b1, va);
        vectors++;
        if (gv !== 1'b1 || res !== 8'd1 || err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL after_abort: got valid=%b result=%0d error=%b expected 1, 1, 0", gv, res, err);
        end
    endtask

`ifdef MODEXP_TIMEOUT_EN
    task automatic test_timeout;
        logic gv, err, b1, va;
        logic [7:0] res;
        int cyc;
        force_low = 1'b1;
        run_op(8'd255, 8'd255, 8'd251, gv, res, err, cyc, b1, va);
        force_low = 1'b0;
        vectors++;
        if (gv !== 1'b1 || err !== 1'b1 || res !== 8'd0 || cyc < TB_TIMEOUT || cyc > TB_TIMEOUT + 4) begin
            miscompares++;
            $display("[TB] FAIL timeout: got valid=%b error=%b result=%0d latency=%0d expected 1, 1, 0, ~%0d",
                     gv, err, res, cyc, TB_TIMEOUT + 3);
        end
    endtask
`endif

    task automatic test_monitors;
        vectors++;
        if (start_wide !== 0 || mod_m_bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL interface_monitor: got wide=%0d mbad=%0d expected 0, 0", start_wide, mod_m_bad);
        end
    endtask

    initial begin
        reset    = 1'b1;
        req      = 1'b0;
        base     = 8'd0;
        exponent = 8'd0;
        modulus  = 8'd0;
        repeat (3) @(negedge clk);
        test_reset();
        test_known();
        test_random();
        test_back_to_back();
        test_reset_in_wait();
`ifdef MODEXP_TIMEOUT_EN
        test_timeout();
`endif
        test_monitors();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
Sequences one shared `modulo` instance to compute result = base^exponent mod modulus by left-to-right square-and-multiply. Owns the DATA_WIDTH x DATA_WIDTH multiplier and drives the modulo unit's start/a/modulant. Skips the modulo unit whenever an operand is already below the modulus. Sits between the crypto top-level request logic and the modulo datapath.

Parameters:
DATA_WIDTH, 8, width of base, modulus, result; must match the attached modulo unit
EXP_WIDTH, 8, exponent width = number of square/multiply iterations
MOD_TIMEOUT, 1024, max cycles in WAIT per modulo op (only used with MODEXP_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  1  start pulse; sampled only in IDLE
base  in  DATA_WIDTH  operand, latched on accepted req
exponent  in  EXP_WIDTH  operand, latched on accepted req
modulus  in  DATA_WIDTH  operand, latched on accepted req
busy  out  1  high from the cycle after acceptance until valid
valid  out  1  one-cycle completion pulse
error  out  1  qualified by valid; modulus==0 (or timeout)
result  out  DATA_WIDTH  held from valid until next completion
mod_a  out  2*DATA_WIDTH+1  modulo unit dividend
mod_m  out  DATA_WIDTH  modulo unit modulant = latched modulus, stable while busy
mod_start  out  1  one-cycle launch pulse to modulo unit
mod_out  in  DATA_WIDTH  modulo unit remainder
mod_done  in  1  modulo unit done level

Behaviour:
- Reset values: busy=0, valid=0, error=0, result=0, mod_start=0, mod_a=0, mod_m=0; state IDLE. Reset mid-operation aborts immediately. The modulo unit has no reset; the next mod_start reinitialises it.
- Registers: m, e, acc, b_r, bit index i (counts EXP_WIDTH-1 down to 0), op tag {RED,SQR,MUL}.
- IDLE: on req latch operands. If modulus==0, go to FINISH with error=1; no mod_start. Otherwise acc = (modulus==1) ? 0 : 1, i = EXP_WIDTH-1, go to REDUCE.
- Op step, shared by REDUCE, SQR and MUL:
  - Form p, zero-extended to 2*DATA_WIDTH+1 bits: REDUCE p=base, SQR p=acc*acc, MUL p=acc*b_r.
  - If p < m: write p to the destination the same cycle (1-cycle op).
  - Else: mod_a<=p, mod_start=1 for exactly one cycle, tag the op, go to WAIT.
  - Destination: REDUCE writes b_r; SQR and MUL write acc.
- WAIT: mod_start=0; mod_a and mod_m held. mod_done is only trusted in WAIT, because the modulo unit clears done on the start edge. On mod_done=1 capture mod_out into the tagged destination and advance.
- Sequencing:
  - REDUCE -> SQR.
  - SQR -> MUL if e[i]=1; else next bit.
  - MUL -> next bit.
  - Next bit: if i==0 go to FINISH, else i-=1 and go to SQR.
- FINISH: result<=acc (0 on error), valid=1 for one cycle, busy=0, return to IDLE. A req in this cycle is ignored.
- req while busy: ignored, no queueing.
- exponent==0: result = 1 mod m.
- Latency: 1 accept + 1 REDUCE + (1 or 1+modulo time) per SQR/MUL + 1 FINISH. Minimum 2+EXP_WIDTH+1 cycles.

Optional Feature:
MODEXP_TIMEOUT_EN.
- Defined: a counter resets on each WAIT entry. If it reaches MOD_TIMEOUT without mod_done, go to FINISH with error=1, result=0.
- Undefined: no counter, WAIT has no exit except mod_done or reset; MOD_TIMEOUT is unused.

Decomposition:
- Package modexp_pkg holds:
  - the state enum {IDLE, REDUCE, SQR, MUL, WAIT, FINISH}
  - the op tag enum {OP_RED, OP_SQR, OP_MUL}
- No sub-module: the multiplier is a single expression. The modulo unit is instantiated beside this block by the parent, not inside it.

Test Plan:
- base=4, exp=13, mod=7 -> valid once, result=4, error=0.
- base=5, exp=0, mod=13 -> result=1; mod_start never pulses (all products below modulus).
- base=200, exp=9, mod=1 -> result=0; REDUCE uses the modulo unit.
- mod=0, any base/exp -> valid 2 cycles after req, error=1, result=0, mod_start never asserted.
- base=255, exp=255, mod=251 -> result=20; every mod_start is exactly 1 cycle wide; mod_m=251 throughout busy.
- reset pulsed while in WAIT, then req base=3, exp=5, mod=11 -> outputs return to reset values immediately, then result=1. With MODEXP_TIMEOUT_EN and mod_done forced low -> error=1 after MOD_TIMEOUT cycles.
